prf_alloc_arbiter: RTL

Physical-register allocation controller for the rename stage. It owns the physical register free bitmap and shares it between REQ_CNT rename requesters using a round-robin arbiter, granting at most one register per cycle. Commit returns retired physical registers through a single free port. It keeps a registered free-register count for decode back-pressure and flags illegal frees.

---
 rtl/prf_alloc_arbiter.sv | 77 +++++++
 1 files changed

// File: rtl/prf_alloc_arbiter.sv
// prf_alloc_arbiter: physical register free-bitmap owner with round-robin single-grant allocation
// and a single commit free port, registered free count and sticky illegal-free flag.
module prf_alloc_arbiter #(
    parameter int PREG_CNT = 64,
    parameter int ARCH_CNT = 32,
    parameter int REQ_CNT  = 2,
    parameter int TW       = $clog2(PREG_CNT)
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic [REQ_CNT-1:0] REQ,
    output logic [REQ_CNT-1:0] GNT,
    output logic [TW-1:0]      GNT_TAG,
    input  logic               FREE_VALID,
    input  logic [TW-1:0]      FREE_TAG,
    output logic [TW:0]        FREE_COUNT,
    output logic               EMPTY,
    output logic               ERROR
);
    localparam int RW = (REQ_CNT > 1) ? $clog2(REQ_CNT) : 1;
    localparam logic [PREG_CNT-1:0] BITMAP_RST = {PREG_CNT{1'b1}} << ARCH_CNT;

    logic [PREG_CNT-1:0] bitmap_q, bitmap_d;
    logic [RW-1:0]       rr_q, rr_d;
    logic [TW:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic [RW-1:0]       win;
    logic [RW-1:0]       idx;
    logic                found, grant, free_ok;
    logic [TW-1:0]       low_tag;

    always_comb begin
        found   = 1'b0;
        win     = '0;
        idx     = '0;
        low_tag = '0;
        for (int k = 0; k < REQ_CNT; k++) begin
            idx = RW'((int'(rr_q) + k) % REQ_CNT);
            if (!found && REQ[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        for (int i = PREG_CNT - 1; i >= 0; i--)
            if (bitmap_q[i]) low_tag = TW'(i);
        // RSTN gating keeps GNT quiet while the async reset is held
        grant   = found && (|bitmap_q) && RSTN;
        GNT     = '0;
        if (grant) GNT[win] = 1'b1;
        GNT_TAG = grant ? low_tag : '0;
        free_ok = FREE_VALID && !bitmap_q[FREE_TAG];
        bitmap_d = bitmap_q;
        if (grant) bitmap_d[low_tag] = 1'b0;
        if (free_ok) bitmap_d[FREE_TAG] = 1'b1;
        rr_d  = grant ? RW'((int'(win) + 1) % REQ_CNT) : rr_q;
        cnt_d = cnt_q + (TW+1)'(free_ok) - (TW+1)'(grant);
        err_d = err_q | (FREE_VALID && !free_ok);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            bitmap_q <= BITMAP_RST;
            rr_q     <= '0;
            cnt_q    <= (TW+1)'(PREG_CNT - ARCH_CNT);
            err_q    <= 1'b0;
        end else begin
            bitmap_q <= bitmap_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign FREE_COUNT = cnt_q;
    assign EMPTY      = (cnt_q == '0);
    assign ERROR      = err_q;
endmodule
